// File: rtl/ds_decimator_if.sv
// Output sample channel of the sinc3 decimator: valid/ready data plus sticky overflow.
interface ds_decimator_if #(
    parameter int C_OUT_BITS = 16
);
    logic [C_OUT_BITS-1:0] DATA;
    logic                  VALID;
    logic                  READY;
    logic                  OVR;
    logic                  CLR_OVR;

    modport master (output DATA, VALID, OVR, input READY, CLR_OVR);
    modport slave  (input DATA, VALID, OVR, output READY, CLR_OVR);
endinterface

// File: rtl/ds_decimator.sv
// Third-order CIC (sinc3) decimator for the 1-bit delta-sigma bitstream,
// with a one-deep valid/ready output register and sticky overflow flag.
//
// state  | meaning
// IDLE   | filter and decimation counter held at zero
// SETTLE | filter running, first two decimated results discarded
// RUN    | every decimated result offered to the output register
module ds_decimator #(
    parameter int C_DEC_LOG2 = 6,
    parameter int C_OUT_BITS = 16
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           EN,
    input  logic           DS_STB,
    input  logic           DS_IN,
    ds_decimator_if.master smp
);
    localparam int W  = 3*C_DEC_LOG2 + 1;
    localparam int SW = 3*C_DEC_LOG2;

    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

    state_t                state;
    logic                  settle_cnt;
    logic [C_DEC_LOG2-1:0] dec_cnt;
    logic [W-1:0]          int1, int2, int3;
    logic [W-1:0]          comb_in, z1, z2, z3;
    logic                  dec_pend;
    logic                  res_vld;
    logic [C_OUT_BITS-1:0] res_q;

    logic [W-1:0]          int1_nx, int2_nx, int3_nx;
    logic [W-1:0]          d1, d2, d3;
    logic [C_OUT_BITS-1:0] res_data;
    logic                  accept, dec_point, filt_clr;
    logic                  unused_d3;

    assign filt_clr  = !EN || (state == IDLE);
    assign accept    = DS_STB && !filt_clr;
    assign dec_point = accept && (dec_cnt == {C_DEC_LOG2{1'b1}});
    assign unused_d3 = ^d3;

    // Integrators chain combinationally so the latched value includes the current bit.
    always_comb begin
        int1_nx  = int1 + {{(W-1){1'b0}}, DS_IN};
        int2_nx  = int2 + int1_nx;
        int3_nx  = int3 + int2_nx;
        d1       = comb_in - z1;
        d2       = d1 - z2;
        d3       = d2 - z3;
        res_data = d3[SW] ? {C_OUT_BITS{1'b1}} : d3[SW-1 -: C_OUT_BITS];
    end

    always_ff @(posedge CLK) begin
        if (RST || filt_clr) begin
            dec_cnt  <= '0;
            int1     <= '0;
            int2     <= '0;
            int3     <= '0;
            comb_in  <= '0;
            z1       <= '0;
            z2       <= '0;
            z3       <= '0;
            dec_pend <= 1'b0;
        end else begin
            dec_pend <= dec_point;
            if (accept) begin
                int1    <= int1_nx;
                int2    <= int2_nx;
                int3    <= int3_nx;
                dec_cnt <= dec_cnt + 1'b1;
            end
            if (dec_point) begin
                comb_in <= int3_nx;
            end
            if (dec_pend) begin
                z1 <= comb_in;
                z2 <= d1;
                z3 <= d2;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            settle_cnt <= 1'b0;
            res_vld    <= 1'b0;
            res_q      <= '0;
        end else if (!EN) begin
            state      <= IDLE;
            settle_cnt <= 1'b0;
            res_vld    <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            case (state)
                IDLE: begin
                    state      <= SETTLE;
                    settle_cnt <= 1'b0;
                end
                SETTLE: begin
                    if (dec_pend) begin
                        if (settle_cnt) begin
                            state <= RUN;
                        end
                        settle_cnt <= 1'b1;
                    end
                end
                RUN: begin
                    if (dec_pend) begin
                        res_vld <= 1'b1;
                        res_q   <= res_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A result arriving while the held sample is not being taken is dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            smp.DATA  <= '0;
            smp.VALID <= 1'b0;
            smp.OVR   <= 1'b0;
        end else begin
            if (res_vld) begin
                if (!smp.VALID || smp.READY) begin
                    smp.DATA  <= res_q;
                    smp.VALID <= 1'b1;
                end
            end else if (smp.VALID && smp.READY) begin
                smp.VALID <= 1'b0;
            end

            if (res_vld && smp.VALID && !smp.READY) begin
                smp.OVR <= 1'b1;
            end else if (smp.CLR_OVR) begin
                smp.OVR <= 1'b0;
            end
        end
    end
endmodule

// File: doc/ds_decimator.md
Name: ds_decimator

Overview:
- Third-order CIC (sinc3) decimation filter that consumes the 1-bit delta-sigma modulator bitstream (the registered comparator output, dsOut) and produces unsigned multi-bit conversion samples.
- Sits directly downstream of the DS modulator flip-flop, in the same clock domain.
- Delivers samples through a valid/ready handshake with a one-deep output register and sticky overflow reporting.

Parameters:
- C_DEC_LOG2, 6, log2 of decimation ratio R (R = 2**C_DEC_LOG2); legal range 2..10.
- C_OUT_BITS, 16, output sample width; must satisfy C_OUT_BITS <= 3*C_DEC_LOG2.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  filter enable; low clears the filter and forces IDLE.
- DS_STB  in  1  modulator-rate strobe; DS_IN is consumed only on cycles with DS_STB=1.
- DS_IN  in  1  modulator bit; 1 = +1, 0 = 0 (unipolar, GND..VDD).
- DATA  out  C_OUT_BITS  decimated sample.
- VALID  out  1  DATA holds an unconsumed sample.
- READY  in  1  downstream accepts DATA when VALID&&READY.
- OVR  out  1  sticky flag: a decimated sample was dropped.
- CLR_OVR  in  1  clears OVR.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: DATA=0, VALID=0, OVR=0, state=IDLE. All integrators, comb delays and the decimation counter are 0.
- Internal width: W = 3*C_DEC_LOG2+1.
- Integrators: three cascaded W-bit integrators, updated only when DS_STB=1 in state SETTLE or RUN.
  - Arithmetic is modular (wrap-around is intentional and required).
  - No saturation inside the integrators.
- Decimation counter: C_DEC_LOG2 bits, increments on each accepted bit.
  - The accepted bit that makes the counter wrap from R-1 to 0 is the decimation point.
  - On that edge, the third integrator value (including that bit) is latched to the comb input.
- Combs: three W-bit differentiators with delay 1 (at the decimated rate), modular arithmetic, evaluated in the single cycle after the decimation point and registered.
- Output scaling: result r (0..R^3).
  - Saturate to 2^(3*C_DEC_LOG2)-1.
  - Right-shift by 3*C_DEC_LOG2-C_OUT_BITS.
  - Defaults: all-ones input gives 0xFFFF; all-zeros gives 0x0000.
- Latency: the scaled sample reaches the output register on the 2nd rising edge after the edge that accepted the decimation-point bit.
- State machine:
  - IDLE: filter cleared and held at 0. When EN=1, go to SETTLE on the next edge.
  - SETTLE: the filter runs, and the first 2 decimated results are computed but discarded (no VALID, no OVR). After the 2nd, go to RUN.
  - RUN: every decimated result is offered to the output stage.
  - Any state: EN=0 returns to IDLE on the next edge and clears the filter and counter. DATA, VALID and OVR are unaffected, so a pending sample can still be drained.
- Output handshake:
  - Transfer occurs on any edge with VALID=1 and READY=1.
  - A new result with VALID=0 loads DATA and sets VALID=1.
  - A new result with VALID=1 and READY=1 on the same edge completes the transfer and loads the new result; VALID stays 1, OVR unchanged.
  - A new result with VALID=1 and READY=0 drops the new result; DATA is held and OVR is set to 1.
  - A transfer with no new result clears VALID.
  - DATA remains stable while VALID=1 and READY=0.
- OVR clearing:
  - OVR clears on an edge with CLR_OVR=1.
  - If a drop and CLR_OVR=1 occur on the same edge, OVR=1 (set wins).
- RST mid-operation: all state returns to reset values on that edge, and any in-flight comb result is discarded.
- DS_STB gaps: any number of idle cycles between strobes has no effect on results; DS_STB may be 1 on every cycle.

Test Plan:
- All ones, DS_STB=1 every cycle, EN=1, READY=1, defaults -> first VALID at 3*64 accepted bits + 2 cycles; DATA=0xFFFF on every sample thereafter.
- All zeros -> every sample is DATA=0x0000, OVR=0.
- Alternating 1,0 with DS_STB every 10th cycle -> settled samples DATA=0x8000 (r=131072), each sample 640 cycles apart.
- Held READY=0 for 3 decimation periods -> first sample stays on DATA with VALID=1, OVR=1 after the 2nd result. CLR_OVR pulse -> OVR=0. READY=1 -> VALID drops the next cycle.
- RST asserted halfway through a decimation period -> next edge: VALID=0, OVR=0, DATA=0. Then all ones -> first VALID again only after a full 3-period settle.
- EN dropped for 1 cycle while VALID=1 -> pending sample still transferable. Filter restarts through SETTLE, and the first new VALID appears only after 2 discarded results.
